// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the byte-serial CLA add sequencer.
// Holds the FSM state encoding, the byte-lane width and the index-width helper.
package cla_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Ceiling log2, floored at 1 so a 2-byte build still gets a 1-bit index.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/cla_add_sequencer_if.sv
// Byte-lane handshake bundle between the tile I/O and the add sequencer.
// Master drives operands and result-side ready; slave is the sequencer.
interface cla_add_sequencer_if;
    import cla_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_a;
    logic [BYTE_W-1:0] in_b;
    logic              in_sub;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_sum;
    logic              out_last;
    logic              out_cout;
    logic              out_ovf;
    logic              busy;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, busy
    );

endinterface

// File: rtl/cla_add_sequencer_cla8.sv
// Combinational 8-bit carry-lookahead adder slice (cla8).
// Every carry is a flat sum of generate/propagate products rather than a ripple chain.
module cla8
    import cla_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout,
    output logic              c7
);

    logic [BYTE_W-1:0] gen_s;
    logic [BYTE_W-1:0] prop_s;
    logic [BYTE_W:0]   carry_s;

    assign gen_s  = a & b;
    assign prop_s = a ^ b;

    // Lookahead carries: c[i] = OR over j<i of g[j]&p[i-1..j+1], plus p[i-1..0]&cin.
    always_comb begin
        logic term_prop;
        logic term_carry;
        carry_s    = {(BYTE_W + 1){1'b0}};
        carry_s[0] = cin;
        for (int i = 1; i <= BYTE_W; i++) begin
            term_prop  = 1'b1;
            term_carry = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
                term_carry = term_carry | (term_prop & gen_s[j]);
                term_prop  = term_prop & prop_s[j];
            end
            carry_s[i] = term_carry | (term_prop & cin);
        end
    end

    assign sum  = prop_s ^ carry_s[BYTE_W-1:0];
    assign cout = carry_s[BYTE_W];
    assign c7   = carry_s[BYTE_W-1];

endmodule

// File: rtl/cla_add_sequencer.sv
// Multi-byte add/sub sequencer: collects NBYTES operand pairs, runs one cla8 pass per
// cycle with a registered carry, then streams result bytes. Subtract needs CLA_SEQ_SUB_EN.
module cla_add_sequencer
    import cla_seq_pkg::*;
#(
    parameter int NBYTES = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    cla_add_sequencer_if.slave    bus
);

    localparam int IDX_W = clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t            state_r;
    logic [IDX_W-1:0]  idx_r;
    logic              carry_r;
    logic              sub_r;
    logic [BYTE_W-1:0] a_r   [NBYTES];
    logic [BYTE_W-1:0] b_r   [NBYTES];
    logic [BYTE_W-1:0] sum_r [NBYTES];

    logic              in_ready_r;
    logic              out_valid_r;
    logic [BYTE_W-1:0] out_sum_r;
    logic              out_last_r;
    logic              out_cout_r;
    logic              out_ovf_r;
    logic              busy_r;

    logic              sub_s;
    logic [IDX_W-1:0]  idx_nxt_s;
    logic              idx_is_last_s;
    logic              nxt_is_last_s;
    logic [BYTE_W-1:0] a_byte_s;
    logic [BYTE_W-1:0] b_eff_s;
    logic [BYTE_W-1:0] cla_sum_s;
    logic              cla_cout_s;
    logic              cla_c7_s;
    logic              ovf_s;

`ifdef CLA_SEQ_SUB_EN
    assign sub_s = bus.in_sub;
`else
    assign sub_s = 1'b0;
`endif

    assign idx_nxt_s     = idx_r + IDX_ONE;
    assign idx_is_last_s = (idx_r == IDX_LAST);
    assign nxt_is_last_s = (idx_nxt_s == IDX_LAST);

    // Operand byte for the current ADD pass; subtract feeds the inverted B byte.
    always_comb begin
        a_byte_s = a_r[idx_r];
        if (sub_r) begin
            b_eff_s = ~b_r[idx_r];
        end else begin
            b_eff_s = b_r[idx_r];
        end
    end

    cla8 u_cla8 (
        .a    (a_byte_s),
        .b    (b_eff_s),
        .cin  (carry_r),
        .sum  (cla_sum_s),
        .cout (cla_cout_s),
        .c7   (cla_c7_s)
    );

    // Carry into the MSB differing from carry out is exactly (a7==b'7)&&(s7!=a7).
    assign ovf_s = cla_c7_s ^ cla_cout_s;

    // Sequencer FSM with all handshake and result outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= {IDX_W{1'b0}};
            carry_r     <= 1'b0;
            sub_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sum_r   <= {BYTE_W{1'b0}};
            out_last_r  <= 1'b0;
            out_cout_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                a_r[i]   <= {BYTE_W{1'b0}};
                b_r[i]   <= {BYTE_W{1'b0}};
                sum_r[i] <= {BYTE_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r[0]  <= bus.in_a;
                        b_r[0]  <= bus.in_b;
                        sub_r   <= sub_s;
                        idx_r   <= IDX_ONE;
                        busy_r  <= 1'b1;
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        a_r[idx_r] <= bus.in_a;
                        b_r[idx_r] <= bus.in_b;
                        if (idx_is_last_s) begin
                            idx_r      <= {IDX_W{1'b0}};
                            carry_r    <= sub_r;
                            in_ready_r <= 1'b0;
                            state_r    <= ADD;
                        end else begin
                            idx_r <= idx_nxt_s;
                        end
                    end
                end
                ADD: begin
                    sum_r[idx_r] <= cla_sum_s;
                    carry_r      <= cla_cout_s;
                    if (idx_is_last_s) begin
                        out_cout_r  <= cla_cout_s;
                        out_ovf_r   <= ovf_s;
                        idx_r       <= {IDX_W{1'b0}};
                        out_valid_r <= 1'b1;
                        // NBYTES >= 2, so byte 0 was written on an earlier pass.
                        out_sum_r   <= sum_r[0];
                        out_last_r  <= 1'b0;
                        state_r     <= OUT;
                    end else begin
                        idx_r <= idx_nxt_s;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (idx_is_last_s) begin
                            idx_r       <= {IDX_W{1'b0}};
                            carry_r     <= 1'b0;
                            out_valid_r <= 1'b0;
                            out_sum_r   <= {BYTE_W{1'b0}};
                            out_last_r  <= 1'b0;
                            in_ready_r  <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= IDLE;
                        end else begin
                            idx_r      <= idx_nxt_s;
                            out_sum_r  <= sum_r[idx_nxt_s];
                            out_last_r <= nxt_is_last_s;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    idx_r       <= {IDX_W{1'b0}};
                    carry_r     <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_cout  = out_cout_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.busy      = busy_r;

endmodule
